// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 shared types, GF(2^8) arithmetic, S-boxes and key-schedule steps
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYX, DEC} state_t;

    localparam logic [79:0] RCON_TAB = 80'h01020408102040801b36;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        if (i >= 4'd1 && i <= 4'd10) return RCON_TAB[8*(10 - int'(i)) +: 8];
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] acc;
        p   = a;
        acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse and maps 0 to 0, as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = gf_mul(a, a);
        for (int i = 1; i < 8; i++) begin
            r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    // Byte 0 sits in bits [127:120]; bytes run down each column first.
    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int i);
        return blk[127 - 8*i -: 8];
    endfunction

    function automatic logic [31:0] get_word(input logic [127:0] blk, input int i);
        return blk[127 - 32*i -: 32];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = get_word(rk, 0) ^ sub_word(rot_word(get_word(rk, 3))) ^ {rc, 24'h0};
        w1 = get_word(rk, 1) ^ w0;
        w2 = get_word(rk, 2) ^ w1;
        w3 = get_word(rk, 3) ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = get_word(rk, 3) ^ get_word(rk, 2);
        w2 = get_word(rk, 2) ^ get_word(rk, 1);
        w1 = get_word(rk, 1) ^ get_word(rk, 0);
        w0 = get_word(rk, 0) ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// rtl/aes_decrypt_if.sv - request/result bundle of the AES-128 decryptor
interface aes_decrypt_if;
    logic         start;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic [127:0] plaintext;
    logic         done;
    logic         busy;

    modport master (output start, ciphertext, key, input plaintext, done, busy);
    modport slave  (input start, ciphertext, key, output plaintext, done, busy);
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round, InvMixColumns skipped when last
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] nxt
);

    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // InvShiftRows is folded into the fetch: row r of column c comes from column c-r.
    always_comb begin
        isb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127 - 8*(4*c + r) -: 8] = inv_sbox(get_byte(st, 4*((c + 4 - r) % 4) + r));
            end
        end
    end

    assign ark = isb ^ rk;
    assign imc = {inv_mix_col(get_word(ark, 0)), inv_mix_col(get_word(ark, 1)),
                  inv_mix_col(get_word(ark, 2)), inv_mix_col(get_word(ark, 3))};
    assign nxt = last ? ark : imc;

endmodule

// File: rtl/aes_decrypt.sv
// rtl/aes_decrypt.sv - iterative AES-128 decryptor, forward then inverse on-the-fly key schedule
module aes_decrypt
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    aes_decrypt_if.slave bus
);

    state_t       state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] pt_q, pt_d;
    logic [3:0]   kcnt_q, kcnt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         done_q, done_d;

    logic [127:0] fwd_rk;
    logic [127:0] prev_rk;
    logic [127:0] round_out;

    assign fwd_rk  = key_fwd(rk_q, rcon(kcnt_q));
    assign prev_rk = key_inv(rk_q, rcon(rnd_q));

    aes_inv_round u_inv_round (
        .st   (st_q),
        .rk   (prev_rk),
        .last (rnd_q == 4'd1),
        .nxt  (round_out)
    );

    always_comb begin
        state_d = state_q;
        ct_d    = ct_q;
        rk_d    = rk_q;
        st_d    = st_q;
        pt_d    = pt_q;
        kcnt_d  = kcnt_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ct_d    = bus.ciphertext;
                    rk_d    = bus.key;
                    kcnt_d  = 4'd1;
                    state_d = KEYX;
                end
            end
            KEYX: begin
                rk_d   = fwd_rk;
                kcnt_d = kcnt_q + 4'd1;
                if (kcnt_q == 4'd10) begin
                    // fwd_rk is round key 10 here: initial AddRoundKey of the inverse cipher.
                    st_d    = ct_q ^ fwd_rk;
                    rnd_d   = 4'd10;
                    kcnt_d  = 4'd0;
                    state_d = DEC;
                end
            end
            DEC: begin
                rk_d  = prev_rk;
                st_d  = round_out;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    pt_d    = round_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ct_q    <= '0;
            rk_q    <= '0;
            st_q    <= '0;
            pt_q    <= '0;
            kcnt_q  <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            rk_q    <= rk_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            kcnt_q  <= kcnt_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign bus.plaintext = pt_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_aes_decrypt.sv
// tb/tb_aes_decrypt.sv - directed and round-trip bench for aes_decrypt
module tb_aes_decrypt;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        logic         chk_rk;
        logic [127:0] rk10;
    } vec_t;

    logic clk;
    logic rst;
    aes_decrypt_if bus_if ();

    aes_decrypt dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus_if)
    );

    int           applied;
    int           miscompares;
    logic [127:0] last_pt;
    logic [7:0]   tb_sb [256];
    vec_t         vecs [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %032h expected %032h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h11b << (i - 8));
        return prod[7:0];
    endfunction

    function automatic logic [7:0] sbox_entry(input int x);
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c63;
        c63 = 8'h63;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
        return s;
    endfunction

    function automatic logic [127:0] tb_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] rk, s;
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [31:0]  w [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        rk = key;
        s  = pt ^ key;
        rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = s[127 - 8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) t[4*c + rw] = tb_sb[b[4*((c + rw) % 4) + rw]];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    b[4*c]   = m_mul(t[4*c], 8'h02) ^ m_mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    b[4*c+1] = t[4*c] ^ m_mul(t[4*c+1], 8'h02) ^ m_mul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    b[4*c+2] = t[4*c] ^ t[4*c+1] ^ m_mul(t[4*c+2], 8'h02) ^ m_mul(t[4*c+3], 8'h03);
                    b[4*c+3] = m_mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ m_mul(t[4*c+3], 8'h02);
                end else begin
                    for (int rw = 0; rw < 4; rw++) b[4*c + rw] = t[4*c + rw];
                end
            end
            for (int i = 0; i < 4; i++) w[i] = rk[127 - 32*i -: 32];
            tmp  = {w[3][23:0], w[3][31:24]};
            tmp  = {tb_sb[tmp[31:24]], tb_sb[tmp[23:16]], tb_sb[tmp[15:8]], tb_sb[tmp[7:0]]};
            w[0] = w[0] ^ tmp ^ {rc, 24'h0};
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            rk   = {w[0], w[1], w[2], w[3]};
            rc   = m_mul(rc, 8'h02);
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = b[i] ^ rk[127 - 8*i -: 8];
        end
        return s;
    endfunction

    // One block from a start pulse; checks result, 20-cycle latency, busy window, hold, done width.
    task automatic run_block(input string name, input logic [127:0] k, input logic [127:0] ct,
                             input logic [127:0] exp_pt, input logic chk_rk,
                             input logic [127:0] exp_rk, input logic toggle);
        int           lat;
        logic         busy_bad;
        logic         hold_bad;
        logic [127:0] got;
        lat      = -1;
        busy_bad = 1'b0;
        hold_bad = 1'b0;
        got      = '0;
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ciphertext = ct;
        bus_if.key        = k;
        @(posedge clk);
        for (int n = 0; n <= 40; n++) begin
            @(negedge clk);
            bus_if.start = (toggle && n <= 19) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (toggle) begin
                bus_if.ciphertext = {$urandom, $urandom, $urandom, $urandom};
                bus_if.key        = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!bus_if.busy) busy_bad = 1'b1;
            if (chk_rk && n == 10) check({name, " rk10"}, dut.rk_q, exp_rk);
            if (bus_if.done) begin
                lat = n;
                got = bus_if.plaintext;
                break;
            end
            if (bus_if.plaintext !== last_pt) hold_bad = 1'b1;
        end
        check({name, " plaintext"}, got, exp_pt);
        check({name, " latency"}, 128'(lat), 128'(20));
        check({name, " busy window"}, {127'b0, busy_bad}, '0);
        check({name, " plaintext hold"}, {127'b0, hold_bad}, '0);
        @(negedge clk);
        check({name, " done/busy after"}, {126'b0, bus_if.done, bus_if.busy}, '0);
        last_pt = exp_pt;
    endtask

    initial begin
        int           first, second, dones;
        logic         hold_bad;
        logic [127:0] rk_key, rk_pt;

        applied           = 0;
        miscompares       = 0;
        last_pt           = '0;
        rst               = 1'b1;
        bus_if.start      = 1'b0;
        bus_if.ciphertext = '0;
        bus_if.key        = '0;
        for (int x = 0; x < 256; x++) tb_sb[x] = sbox_entry(x);

        vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, 1'b1, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 1'b0, 128'h0};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a, 1'b0, 128'h0};
        vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b0, 128'h0};

        #3;
        check("reset plaintext", bus_if.plaintext, '0);
        check("reset done/busy", {126'b0, bus_if.done, bus_if.busy}, '0);
        check("reset counters", {120'b0, dut.kcnt_q, dut.rnd_q}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_block($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt,
                      vecs[i].chk_rk, vecs[i].rk10, 1'(i % 2));

        // Back-to-back with start held high across both blocks.
        first    = -1;
        second   = -1;
        hold_bad = 1'b0;
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ciphertext = vecs[0].ct;
        bus_if.key        = vecs[0].key;
        @(posedge clk);
        for (int n = 0; n <= 60; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus_if.ciphertext = vecs[1].ct;
                bus_if.key        = vecs[1].key;
            end
            if (bus_if.done) begin
                if (first < 0) begin
                    first = n;
                    check("b2b first plaintext", bus_if.plaintext, vecs[0].pt);
                end else begin
                    second       = n;
                    bus_if.start = 1'b0;
                    check("b2b second plaintext", bus_if.plaintext, vecs[1].pt);
                    break;
                end
            end else if (first >= 0 && bus_if.plaintext !== vecs[0].pt) begin
                hold_bad = 1'b1;
            end
        end
        bus_if.start = 1'b0;
        check("b2b first latency", 128'(first), 128'(20));
        check("b2b done spacing", 128'(second - first), 128'(21));
        check("b2b plaintext hold", {127'b0, hold_bad}, '0);
        last_pt = vecs[1].pt;

        // Reset in the middle of DEC.
        @(negedge clk);
        bus_if.start      = 1'b1;
        bus_if.ciphertext = vecs[0].ct;
        bus_if.key        = vecs[0].key;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid-reset plaintext", bus_if.plaintext, '0);
        check("mid-reset done/busy", {126'b0, bus_if.done, bus_if.busy}, '0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus_if.done) dones++;
        end
        check("mid-reset no done", 128'(dones), '0);
        last_pt = '0;
        run_block("post-reset C.1", vecs[0].key, vecs[0].ct, vecs[0].pt, 1'b1, vecs[0].rk10, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            rk_key = {$urandom, $urandom, $urandom, $urandom};
            rk_pt  = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("rt%0d", i), rk_key, tb_encrypt(rk_key, rk_pt), rk_pt,
                      1'b0, '0, 1'(i % 3 == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
